rv_mc_ctrl: RTL and testbench
=============================

# rv_mc_ctrl

Multi-cycle control unit for the RV32I core. It sits downstream of the fetch/decode front end. It consumes the decoded `opcode`/`funct3`/`funct7` fields and the ALU zero flag. It drives every write strobe and datapath select of the multi-cycle datapath, including the `PC_Write` and `IR_Write` strobes that step the fetch stage. It also keeps a retired-instruction counter for the board LED/segment display.

## Interface
Parameters:
- none

Ports:
- `clk` in 1 — system clock; all state updates on the rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `opcode` in 7 — decoded inst[6:0]; stable from the end of FETCH until the next FETCH.
- `funct3` in 3 — decoded inst[14:12].
- `funct7` in 7 — decoded inst[31:25].
- `zf` in 1 — ALU zero flag, valid in the cycle the ALU computes.
- `PC_Write` out 1 — PC load strobe.
- `PC0_Write` out 1 — latch current PC into PC0 (address of the current instruction).
- `IR_Write` out 1 — instruction register load strobe.
- `AB_Write` out 1 — latch rs1/rs2 read data into A/B.
- `F_Write` out 1 — latch ALU result into F.
- `MDR_Write` out 1 — latch memory read data.
- `Mem_Write` out 1 — data memory write.
- `Reg_Write` out 1 — register file write.
- `ALU_OP` out 4 — 0000 ADD, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 0110 OR, 0111 AND, 1000 SUB, 1101 SRA.
- `rs2_imm_s` out 1 — ALU B source: 0 = B, 1 = imm32.
- `PC_s` out 2 — PC source: 00 = PC+4, 01 = F, 10 = PC0+imm32.
- `w_data_s` out 2 — register write data: 00 = F, 01 = imm32, 10 = PC, 11 = MDR.
- `trap` out 1 — illegal instruction seen; sticky.
- `state` out 4 — current state encoding, for debug.
- `instret` out 32 — retired-instruction count.

## Operation
States and encoding: IDLE 0, FETCH 1, DECODE 2, EX_R 3, EX_I 4, WB_ALU 5, LUI 6, MEM_ADDR 7, LOAD_RD 8, LOAD_WB 9, STORE 10, BRANCH 11, JAL 12, TRAP 13.

Transitions:
- IDLE→FETCH.
- FETCH→DECODE.
- DECODE decodes by opcode:
  - 0110011→EX_R
  - 0010011→EX_I
  - 0110111→LUI
  - 0000011 or 0100011 with funct3=010→MEM_ADDR
  - 1100011 with funct3∈{000,001}→BRANCH
  - 1101111→JAL
  - anything else→TRAP
- EX_R/EX_I→WB_ALU→FETCH.
- MEM_ADDR→LOAD_RD if opcode=0000011, else STORE.
- LOAD_RD→LOAD_WB→FETCH.
- LUI, STORE, BRANCH, JAL→FETCH.
- TRAP→TRAP; only reset exits.

Outputs are a function of state only (Moore), with one exception: `PC_Write` in BRANCH also depends on `zf`. Any output not listed for a state is 0.
- FETCH: IR_Write=1, PC_Write=1, PC0_Write=1, PC_s=00.
- DECODE: AB_Write=1.
- EX_R: F_Write=1, rs2_imm_s=0, ALU_OP={funct7[5],funct3}.
- EX_I: F_Write=1, rs2_imm_s=1. ALU_OP={funct7[5],funct3} when funct3=101, else {0,funct3}.
- WB_ALU: Reg_Write=1, w_data_s=00.
- LUI: Reg_Write=1, w_data_s=01.
- MEM_ADDR: F_Write=1, rs2_imm_s=1, ALU_OP=ADD.
- LOAD_RD: MDR_Write=1.
- LOAD_WB: Reg_Write=1, w_data_s=11.
- STORE: Mem_Write=1.
- BRANCH:
  - ALU_OP=SUB, rs2_imm_s=0, PC_s=10.
  - PC_Write=zf when funct3=000 (BEQ); PC_Write=~zf when funct3=001 (BNE).
- JAL: Reg_Write=1, w_data_s=10, PC_Write=1, PC_s=10. The register file captures the old PC (already PC0+4) in the same edge that loads the new PC.
- TRAP: trap=1. All strobes stay 0, so the PC freezes.

`instret` increments by 1 on every edge that leaves WB_ALU, LUI, LOAD_WB, STORE, BRANCH or JAL. It wraps from 0xFFFFFFFF to 0. A not-taken branch still counts.

## Timing
- Reset (`rst_n`=0, asynchronous, any state, including mid-instruction): state=IDLE, instret=0, trap=0, every strobe 0, ALU_OP=0000, all selects 0. Strobes go low immediately, without waiting for a clock edge.
- First FETCH occurs 1 cycle after reset is released.
- Cycles per instruction (FETCH through last state):
  - R/I-ALU: 4
  - LUI, BRANCH, JAL: 3
  - load: 5
  - store: 4
- `instret` updates on the same edge that enters FETCH.
- `opcode`/`funct` fields are sampled combinationally. Upstream holds them stable because IR_Write is asserted only in FETCH.

## Test plan
- Reset release with inst `add x3,x1,x2` (0x002081B3) → state sequence 0,1,2,3,5,1. Reg_Write is high only in state 5. ALU_OP=0000. instret becomes 1 on entering FETCH.
- `srai x5,x5,3` (funct3=101, funct7=0100000) → ALU_OP=1101, rs2_imm_s=1 in EX_I. `sub` → ALU_OP=1000 in EX_R.
- `lw` (opcode 0000011, funct3=010) → states 1,2,7,8,9,1: MDR_Write in 8, w_data_s=11 with Reg_Write in 9. `sw` → Mem_Write for exactly 1 cycle in state 10.
- BEQ with zf=1 → PC_Write=1, PC_s=10 in BRANCH. BEQ with zf=0 → PC_Write=0. BNE inverts both cases. instret increments in all four cases.
- Opcode 0000000 → DECODE→TRAP. trap stays 1 and all strobes stay 0 for 100 cycles. A `rst_n` pulse returns state=0, trap=0, instret=0.
- Assert `rst_n`=0 mid-load (state 8) → outputs clear asynchronously before the next edge. Separately, preload instret=0xFFFFFFFF and retire one instruction → instret=0.

Source files
------------

// File: rtl/rv_mc_ctrl.sv
// rtl/rv_mc_ctrl.sv - RV32I multi-cycle control FSM with retired-instruction counter
module rv_mc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        zf,
  output logic        PC_Write,
  output logic        PC0_Write,
  output logic        IR_Write,
  output logic        AB_Write,
  output logic        F_Write,
  output logic        MDR_Write,
  output logic        Mem_Write,
  output logic        Reg_Write,
  output logic [3:0]  ALU_OP,
  output logic        rs2_imm_s,
  output logic [1:0]  PC_s,
  output logic [1:0]  w_data_s,
  output logic        trap,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EX_R     = 4'd3,
    S_EX_I     = 4'd4,
    S_WB_ALU   = 4'd5,
    S_LUI      = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_LOAD_RD  = 4'd8,
    S_LOAD_WB  = 4'd9,
    S_STORE    = 4'd10,
    S_BRANCH   = 4'd11,
    S_JAL      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instret_q, instret_d;

  // Only funct7[5] distinguishes SUB/SRA; the rest of the field is don't-care here.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          7'b0110011: state_d = S_EX_R;
          7'b0010011: state_d = S_EX_I;
          7'b0110111: state_d = S_LUI;
          7'b0000011,
          7'b0100011: state_d = (funct3 == 3'b010) ? S_MEM_ADDR : S_TRAP;
          7'b1100011: state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_TRAP;
          7'b1101111: state_d = S_JAL;
          default:    state_d = S_TRAP;
        endcase
      end
      S_EX_R, S_EX_I: state_d = S_WB_ALU;
      S_MEM_ADDR:     state_d = (opcode == 7'b0000011) ? S_LOAD_RD : S_STORE;
      S_LOAD_RD:      state_d = S_LOAD_WB;
      S_WB_ALU, S_LUI, S_LOAD_WB, S_STORE, S_BRANCH, S_JAL: begin
        state_d   = S_FETCH;
        instret_d = instret_q + 32'd1;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decode from the registered state, so an asynchronous reset clears them at once.
  always_comb begin
    PC_Write  = 1'b0;
    PC0_Write = 1'b0;
    IR_Write  = 1'b0;
    AB_Write  = 1'b0;
    F_Write   = 1'b0;
    MDR_Write = 1'b0;
    Mem_Write = 1'b0;
    Reg_Write = 1'b0;
    ALU_OP    = 4'b0000;
    rs2_imm_s = 1'b0;
    PC_s      = 2'b00;
    w_data_s  = 2'b00;
    trap      = 1'b0;
    case (state_q)
      S_FETCH: begin
        IR_Write  = 1'b1;
        PC_Write  = 1'b1;
        PC0_Write = 1'b1;
      end
      S_DECODE: AB_Write = 1'b1;
      S_EX_R: begin
        F_Write = 1'b1;
        ALU_OP  = {funct7[5], funct3};
      end
      S_EX_I: begin
        F_Write   = 1'b1;
        rs2_imm_s = 1'b1;
        ALU_OP    = (funct3 == 3'b101) ? {funct7[5], funct3} : {1'b0, funct3};
      end
      S_WB_ALU: Reg_Write = 1'b1;
      S_LUI: begin
        Reg_Write = 1'b1;
        w_data_s  = 2'b01;
      end
      S_MEM_ADDR: begin
        F_Write   = 1'b1;
        rs2_imm_s = 1'b1;
      end
      S_LOAD_RD: MDR_Write = 1'b1;
      S_LOAD_WB: begin
        Reg_Write = 1'b1;
        w_data_s  = 2'b11;
      end
      S_STORE: Mem_Write = 1'b1;
      S_BRANCH: begin
        ALU_OP   = 4'b1000;
        PC_s     = 2'b10;
        PC_Write = (funct3 == 3'b001) ? ~zf : zf;
      end
      S_JAL: begin
        Reg_Write = 1'b1;
        w_data_s  = 2'b10;
        PC_Write  = 1'b1;
        PC_s      = 2'b10;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// tb/tb_rv_mc_ctrl.sv - scoreboard bench for rv_mc_ctrl, one expected vector per sampled cycle
module tb_rv_mc_ctrl;

  logic        clk, rst_n;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        zf;
  logic        PC_Write, PC0_Write, IR_Write, AB_Write, F_Write, MDR_Write, Mem_Write, Reg_Write;
  logic [3:0]  ALU_OP, state;
  logic        rs2_imm_s, trap;
  logic [1:0]  PC_s, w_data_s;
  logic [31:0] instret;

  rv_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7), .zf(zf),
    .PC_Write(PC_Write), .PC0_Write(PC0_Write), .IR_Write(IR_Write), .AB_Write(AB_Write),
    .F_Write(F_Write), .MDR_Write(MDR_Write), .Mem_Write(Mem_Write), .Reg_Write(Reg_Write),
    .ALU_OP(ALU_OP), .rs2_imm_s(rs2_imm_s), .PC_s(PC_s), .w_data_s(w_data_s),
    .trap(trap), .state(state), .instret(instret)
  );

  // stb = {PC_Write, PC0_Write, IR_Write, AB_Write, F_Write, MDR_Write, Mem_Write, Reg_Write}
  typedef struct packed {
    logic [3:0]  st;
    logic [7:0]  stb;
    logic [3:0]  aop;
    logic        rs2;
    logic [1:0]  pcs;
    logic [1:0]  wds;
    logic        tr;
    logic [31:0] ir;
  } vec_t;

  localparam int K_R = 0, K_I = 1, K_LUI = 2, K_LD = 3, K_ST = 4, K_BR = 5, K_JAL = 6;

  vec_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_instret = 32'd0;
  string       cur_tag = "init";

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input [3:0] st, input [7:0] stb, input [3:0] aop,
                             input logic rs2, input [1:0] pcs, input [1:0] wds, input logic tr);
    vec_t r;
    r = {st, stb, aop, rs2, pcs, wds, tr, exp_instret};
    return r;
  endfunction

  function automatic vec_t obs();
    vec_t r;
    r = {state, PC_Write, PC0_Write, IR_Write, AB_Write, F_Write, MDR_Write, Mem_Write,
         Reg_Write, ALU_OP, rs2_imm_s, PC_s, w_data_s, trap, instret};
    return r;
  endfunction

  task automatic check_now();
    vec_t e, o;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed state %0d", cur_tag, state);
    end else begin
      e = exp_q.pop_front();
      o = obs();
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s: observed st=%0d vec=%h, expected st=%0d vec=%h", cur_tag, o.st, o, e.st, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_now();
  endtask

  task automatic drain();
    while (exp_q.size() > 0) step();
  endtask

  // Called at a negedge while in FETCH; runs the instruction through to the next FETCH.
  task automatic issue(input string tag, input [6:0] opc, input [2:0] f3, input [6:0] f7,
                       input logic z, input int kind, input [3:0] aop, input logic tk);
    cur_tag = tag;
    opcode = opc; funct3 = f3; funct7 = f7; zf = z;
    exp_q.push_back(v(4'd2, 8'b0001_0000, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
    case (kind)
      K_R: begin
        exp_q.push_back(v(4'd3, 8'b0000_1000, aop, 1'b0, 2'b00, 2'b00, 1'b0));
        exp_q.push_back(v(4'd5, 8'b0000_0001, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
      end
      K_I: begin
        exp_q.push_back(v(4'd4, 8'b0000_1000, aop, 1'b1, 2'b00, 2'b00, 1'b0));
        exp_q.push_back(v(4'd5, 8'b0000_0001, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
      end
      K_LUI: exp_q.push_back(v(4'd6, 8'b0000_0001, 4'd0, 1'b0, 2'b00, 2'b01, 1'b0));
      K_LD: begin
        exp_q.push_back(v(4'd7, 8'b0000_1000, 4'd0, 1'b1, 2'b00, 2'b00, 1'b0));
        exp_q.push_back(v(4'd8, 8'b0000_0100, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
        exp_q.push_back(v(4'd9, 8'b0000_0001, 4'd0, 1'b0, 2'b00, 2'b11, 1'b0));
      end
      K_ST: begin
        exp_q.push_back(v(4'd7, 8'b0000_1000, 4'd0, 1'b1, 2'b00, 2'b00, 1'b0));
        exp_q.push_back(v(4'd10, 8'b0000_0010, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
      end
      K_BR:  exp_q.push_back(v(4'd11, {tk, 7'b0}, 4'b1000, 1'b0, 2'b10, 2'b00, 1'b0));
      default: exp_q.push_back(v(4'd12, 8'b1000_0001, 4'd0, 1'b0, 2'b10, 2'b10, 1'b0));
    endcase
    exp_instret = exp_instret + 32'd1;
    exp_q.push_back(v(4'd1, 8'b1110_0000, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
    drain();
  endtask

  // Mid-cycle asynchronous reset pulse, released on the following negedge.
  task automatic async_reset(input string tag);
    cur_tag = tag;
    #2 rst_n = 1'b0;
    #1;
    exp_instret = 32'd0;
    exp_q.push_back(v(4'd0, 8'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
    check_now();
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(v(4'd0, 8'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
    check_now();
    cur_tag = {tag, "_first_fetch"};
    exp_q.push_back(v(4'd1, 8'b1110_0000, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
    step();
  endtask

  initial begin
    rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; zf = 1'b0;
    repeat (2) @(negedge clk);
    cur_tag = "reset_state";
    exp_q.push_back(v(4'd0, 8'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
    check_now();
    rst_n = 1'b1;
    exp_q.push_back(v(4'd0, 8'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
    check_now();
    cur_tag = "first_fetch";
    exp_q.push_back(v(4'd1, 8'b1110_0000, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
    step();

    issue("add",   7'b0110011, 3'b000, 7'b0000000, 1'b0, K_R,   4'b0000, 1'b0);
    issue("sub",   7'b0110011, 3'b000, 7'b0100000, 1'b0, K_R,   4'b1000, 1'b0);
    issue("sra",   7'b0110011, 3'b101, 7'b0100000, 1'b0, K_R,   4'b1101, 1'b0);
    issue("srai",  7'b0010011, 3'b101, 7'b0100000, 1'b0, K_I,   4'b1101, 1'b0);
    issue("addi",  7'b0010011, 3'b000, 7'b0100000, 1'b0, K_I,   4'b0000, 1'b0);
    issue("xori",  7'b0010011, 3'b100, 7'b1111111, 1'b0, K_I,   4'b0100, 1'b0);
    issue("lui",   7'b0110111, 3'b011, 7'b0000000, 1'b0, K_LUI, 4'b0000, 1'b0);
    issue("lw",    7'b0000011, 3'b010, 7'b0000000, 1'b0, K_LD,  4'b0000, 1'b0);
    issue("sw",    7'b0100011, 3'b010, 7'b0000000, 1'b0, K_ST,  4'b0000, 1'b0);
    issue("beq_t", 7'b1100011, 3'b000, 7'b0000000, 1'b1, K_BR,  4'b0000, 1'b1);
    issue("beq_n", 7'b1100011, 3'b000, 7'b0000000, 1'b0, K_BR,  4'b0000, 1'b0);
    issue("bne_n", 7'b1100011, 3'b001, 7'b0000000, 1'b1, K_BR,  4'b0000, 1'b0);
    issue("bne_t", 7'b1100011, 3'b001, 7'b0000000, 1'b0, K_BR,  4'b0000, 1'b1);
    issue("jal",   7'b1101111, 3'b000, 7'b0000000, 1'b0, K_JAL, 4'b0000, 1'b0);

    cur_tag = "trap";
    opcode = 7'b0000000; funct3 = 3'b000; funct7 = 7'd0;
    exp_q.push_back(v(4'd2, 8'b0001_0000, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
    for (int i = 0; i < 100; i++)
      exp_q.push_back(v(4'd13, 8'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b1));
    drain();
    async_reset("trap_reset");

    cur_tag = "lb_trap";
    opcode = 7'b0000011; funct3 = 3'b000;
    exp_q.push_back(v(4'd2, 8'b0001_0000, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
    exp_q.push_back(v(4'd13, 8'b0, 4'd0, 1'b0, 2'b00, 2'b00, 1'b1));
    drain();
    async_reset("lb_reset");

    issue("add2", 7'b0110011, 3'b111, 7'b0000000, 1'b0, K_R, 4'b0111, 1'b0);
    cur_tag = "lw_abort";
    opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'd0;
    exp_q.push_back(v(4'd2, 8'b0001_0000, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
    exp_q.push_back(v(4'd7, 8'b0000_1000, 4'd0, 1'b1, 2'b00, 2'b00, 1'b0));
    exp_q.push_back(v(4'd8, 8'b0000_0100, 4'd0, 1'b0, 2'b00, 2'b00, 1'b0));
    drain();
    async_reset("load_reset");

    dut.instret_q = 32'hFFFF_FFFF;
    exp_instret = 32'hFFFF_FFFF;
    issue("wrap_lui", 7'b0110111, 3'b000, 7'b0000000, 1'b0, K_LUI, 4'b0000, 1'b0);
    issue("post_wrap", 7'b0100011, 3'b010, 7'b0000000, 1'b0, K_ST, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
